// File: rtl/map_loader.sv
// Lane map store writer: clears a LANES x ROWS cell RAM, then fills it row-major from a
// valid/ready cell stream, and serves a registered, masked read port with state and colour.
module map_loader #(
   parameter int LANES = 5,
   parameter int ROWS  = 100
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [2:0]  in_cell_i,
   input  logic        in_last_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        map_valid_o,
   output logic [10:0] len_o,
   input  logic [2:0]  rd_x_i,
   input  logic [6:0]  rd_y_i,
   output logic [2:0]  rd_state_o,
   output logic [11:0] rd_rgb_o
);

   localparam int CELLS = LANES * ROWS;
   localparam int AW    = $clog2(CELLS);

   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_LOAD, S_DONE} state_t;

   state_t          state_q;
   logic [2:0]      x_q;
   logic [6:0]      y_q;
   logic [AW-1:0]   clr_q;
   logic            in_ready_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;
   logic            map_valid_q;
   logic [10:0]     len_q;
   logic [2:0]      rd_state_q;
   logic [11:0]     rd_rgb_q;
   logic [2:0]      mem_q [CELLS];

   logic            accept_d;
   logic            last_slot_d;
   logic            wr_en_d;
   logic [AW-1:0]   wr_addr_d;
   logic [2:0]      wr_data_d;
   logic            rd_in_range_d;
   logic [AW-1:0]   rd_addr_d;

   function automatic logic [11:0] rgb_of(input logic [2:0] code);
      case (code)
         3'd1:    rgb_of = 12'hF00;
         3'd2:    rgb_of = 12'hFF0;
         default: rgb_of = 12'h000;
      endcase
   endfunction

   assign accept_d      = in_valid_i && in_ready_q;
   assign last_slot_d   = (x_q == 3'(LANES - 1)) && (y_q == 7'(ROWS - 1));
   assign rd_in_range_d = (int'(rd_x_i) < LANES) && (int'(rd_y_i) < ROWS);
   // Out-of-range reads are steered to cell 0 and masked at the output register.
   assign rd_addr_d     = rd_in_range_d ? AW'(int'(rd_y_i) * LANES + int'(rd_x_i)) : '0;

   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = clr_q;
      wr_data_d = 3'd0;
      if (state_q == S_CLEAR) begin
         wr_en_d = 1'b1;
      end else if (accept_d) begin
         wr_en_d   = 1'b1;
         wr_addr_d = AW'(int'(y_q) * LANES + int'(x_q));
         wr_data_d = (in_cell_i > 3'd2) ? 3'd0 : in_cell_i;
      end else begin
         wr_en_d = 1'b0;
      end
   end

   // Cell RAM: no reset; contents are hidden until a load completes.
   always_ff @(posedge clk_i) begin
      if (wr_en_d) begin
         mem_q[wr_addr_d] <= wr_data_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         x_q         <= 3'd0;
         y_q         <= 7'd0;
         clr_q       <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         map_valid_q <= 1'b0;
         len_q       <= 11'd0;
         rd_state_q  <= 3'd0;
         rd_rgb_q    <= 12'h000;
      end else begin
         done_q <= 1'b0;
         if (map_valid_q && rd_in_range_d) begin
            rd_state_q <= mem_q[rd_addr_d];
            rd_rgb_q   <= rgb_of(mem_q[rd_addr_d]);
         end else begin
            rd_state_q <= 3'd0;
            rd_rgb_q   <= 12'h000;
         end
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_q     <= S_CLEAR;
                  busy_q      <= 1'b1;
                  err_q       <= 1'b0;
                  map_valid_q <= 1'b0;
                  clr_q       <= '0;
                  x_q         <= 3'd0;
                  y_q         <= 7'd0;
               end
            end
            S_CLEAR: begin
               if (clr_q == AW'(CELLS - 1)) begin
                  state_q    <= S_LOAD;
                  in_ready_q <= 1'b1;
               end else begin
                  clr_q <= clr_q + 1'b1;
               end
            end
            S_LOAD: begin
               if (accept_d) begin
                  if (in_cell_i > 3'd2) begin
                     err_q <= 1'b1;
                  end
                  // A last cell in the final slot is a legal full map, not an overflow.
                  if (in_last_i || last_slot_d) begin
                     if (in_last_i) begin
                        len_q <= 11'(y_q) + 11'd1;
                     end else begin
                        len_q <= 11'(ROWS);
                        err_q <= 1'b1;
                     end
                     state_q     <= S_DONE;
                     in_ready_q  <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     map_valid_q <= 1'b1;
                  end else if (x_q == 3'(LANES - 1)) begin
                     x_q <= 3'd0;
                     y_q <= y_q + 7'd1;
                  end else begin
                     x_q <= x_q + 3'd1;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready_o  = in_ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign map_valid_o = map_valid_q;
   assign len_o       = len_q;
   assign rd_state_o  = rd_state_q;
   assign rd_rgb_o    = rd_rgb_q;

endmodule

// File: tb/tb_map_loader.sv
// Directed bench for map_loader: table-driven read checks plus hand-written load sequences.
module tb_map_loader;

   logic        clk = 1'b0;
   logic        rst_n, start, in_valid, in_ready, in_last, busy, done, err, map_valid;
   logic [2:0]  in_cell, rd_x, rd_state;
   logic [6:0]  rd_y;
   logic [10:0] len;
   logic [11:0] rd_rgb;

   int total = 0;
   int bad   = 0;
   int n;

   typedef struct {
      logic [2:0]  x;
      logic [6:0]  y;
      logic [2:0]  st;
      logic [11:0] rgb;
   } rd_vec_t;

   rd_vec_t vecs [15];

   always #5 clk = ~clk;

   map_loader #(.LANES(5), .ROWS(100)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .in_cell_i(in_cell), .in_last_i(in_last), .busy_o(busy),
      .done_o(done), .err_o(err), .map_valid_o(map_valid), .len_o(len),
      .rd_x_i(rd_x), .rd_y_i(rd_y), .rd_state_o(rd_state), .rd_rgb_o(rd_rgb)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic rd(input string nm, input logic [2:0] x, input logic [6:0] y,
                     input logic [2:0] st, input logic [11:0] rgb);
      rd_x = x;
      rd_y = y;
      tick();
      chk({nm, "_state"}, 32'(rd_state), 32'(st));
      chk({nm, "_rgb"}, 32'(rd_rgb), 32'(rgb));
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Counts edges until in_ready rises, jabbing junk cells (and optionally a start) meanwhile.
   task automatic wait_ready(input int glitch_at, output int cnt);
      cnt = 0;
      while (!in_ready && cnt < 2000) begin
         in_valid = 1'($urandom_range(0, 1));
         in_cell  = 3'd7;
         in_last  = 1'b1;
         start    = (cnt == glitch_at);
         tick();
         cnt++;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_cell  = 3'd0;
   endtask

   task automatic send(input logic [2:0] c, input logic l, input bit gaps);
      logic acc;
      int   k;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            tick();
         end
      end
      in_valid = 1'b1;
      in_cell  = c;
      in_last  = l;
      k = 0;
      do begin
         acc = in_ready;
         tick();
         k++;
      end while (!acc && k < 50);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!acc) chk("send_timeout", 32'(acc), 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0] cells [12];
      cells = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd0};
      vecs[0]  = '{3'd0, 7'd0,   3'd1, 12'hF00};
      vecs[1]  = '{3'd1, 7'd0,   3'd2, 12'hFF0};
      vecs[2]  = '{3'd2, 7'd0,   3'd0, 12'h000};
      vecs[3]  = '{3'd3, 7'd0,   3'd1, 12'hF00};
      vecs[4]  = '{3'd4, 7'd0,   3'd2, 12'hFF0};
      vecs[5]  = '{3'd0, 7'd1,   3'd1, 12'hF00};
      vecs[6]  = '{3'd4, 7'd1,   3'd1, 12'hF00};
      vecs[7]  = '{3'd0, 7'd2,   3'd2, 12'hFF0};
      vecs[8]  = '{3'd1, 7'd2,   3'd0, 12'h000};
      vecs[9]  = '{3'd2, 7'd2,   3'd0, 12'h000};
      vecs[10] = '{3'd3, 7'd2,   3'd0, 12'h000};
      vecs[11] = '{3'd0, 7'd3,   3'd0, 12'h000};
      vecs[12] = '{3'd5, 7'd0,   3'd0, 12'h000};
      vecs[13] = '{3'd0, 7'd100, 3'd0, 12'h000};
      vecs[14] = '{3'd7, 7'd127, 3'd0, 12'h000};

      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_cell = 3'd0; in_last = 1'b0;
      rd_x = 3'd0; rd_y = 7'd0;
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_map_valid", 32'(map_valid), 32'd0);
      chk("rst_len", 32'(len), 32'd0);
      rst_n = 1'b1;
      rd("rst_rd00", 3'd0, 7'd0, 3'd0, 12'h000);

      // Twelve-cell map, with junk cells offered throughout CLEAR.
      pulse_start();
      chk("clr_busy", 32'(busy), 32'd1);
      wait_ready(-1, n);
      chk("clear_cycles", 32'(n), 32'd500);
      for (int i = 0; i < 12; i++) send(cells[i], (i == 11), 1'b0);
      chk("m1_done", 32'(done), 32'd1);
      chk("m1_len", 32'(len), 32'd3);
      chk("m1_map_valid", 32'(map_valid), 32'd1);
      chk("m1_in_ready", 32'(in_ready), 32'd0);
      chk("m1_err", 32'(err), 32'd0);
      chk("m1_busy", 32'(busy), 32'd0);
      tick();
      chk("m1_done_pulse", 32'(done), 32'd0);
      for (int i = 0; i < 15; i++) begin
         rd($sformatf("m1_rd%0d", i), vecs[i].x, vecs[i].y, vecs[i].st, vecs[i].rgb);
      end

      // Illegal code becomes 0 and sets err; the next start clears err.
      pulse_start();
      wait_ready(-1, n);
      send(3'd5, 1'b1, 1'b0);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_len", 32'(len), 32'd1);
      chk("ill_done", 32'(done), 32'd1);
      rd("ill_rd00", 3'd0, 7'd0, 3'd0, 12'h000);
      pulse_start();
      chk("ill_err_cleared", 32'(err), 32'd0);
      chk("ill_map_valid_cleared", 32'(map_valid), 32'd0);
      wait_ready(20, n);
      chk("start_ignored_in_clear", 32'(n), 32'd500);

      // Overflow: 500 cells with random gaps and no in_last.
      for (int i = 0; i < 500; i++) send(3'(i % 3), 1'b0, 1'b1);
      chk("ovf_done", 32'(done), 32'd1);
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_len", 32'(len), 32'd100);
      chk("ovf_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_cell  = 3'd1;
      repeat (3) tick();
      in_valid = 1'b0;
      chk("ovf_no_more_ready", 32'(in_ready), 32'd0);
      chk("ovf_len_held", 32'(len), 32'd100);
      foreach (vecs[j]) begin
         int a;
         a = (j * 37) % 500;
         rd($sformatf("ovf_rd%0d", a), 3'(a % 5), 7'(a / 5), 3'(a % 3),
            (a % 3 == 1) ? 12'hF00 : ((a % 3 == 2) ? 12'hFF0 : 12'h000));
      end
      rd("ovf_rd499", 3'd4, 7'd99, 3'd1, 12'hF00);

      // Old map must be hidden as soon as a new load starts; the read costs one CLEAR edge.
      pulse_start();
      rd("restart_mask", 3'd4, 7'd99, 3'd0, 12'h000);
      wait_ready(-1, n);
      chk("restart_clear_cycles", 32'(n), 32'd499);
      for (int i = 0; i < 7; i++) send(3'd1, 1'b0, 1'b0);
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_map_valid", 32'(map_valid), 32'd0);
      chk("mid_rst_len", 32'(len), 32'd0);
      rst_n = 1'b1;
      rd("mid_rst_rd00", 3'd0, 7'd0, 3'd0, 12'h000);
      rd("mid_rst_rd10", 3'd1, 7'd0, 3'd0, 12'h000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
